// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART with ready/valid TX and framing-error detection.
// Optional parity bit between data and stop bits when `UART_PARITY_EN is defined.
module uart_param #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 15,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              rxd,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              rx_frame_err,
   output logic              rx_parity_err,
   output logic              txd,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_W);
   localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] DLAST     = BW'(DATA_W - 1);
   localparam logic          SLAST     = 1'(STOP_BITS - 1);

   if (DATA_W < 5 || DATA_W > 16 || CLKS_PER_BIT < 4 || (STOP_BITS != 1 && STOP_BITS != 2) ||
       (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
      $error("uart_param: illegal parameter value");
   end

`ifdef UART_PARITY_EN
   localparam logic ODD = (PARITY_ODD != 0);
   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_WAIT} rx_state_t;
   typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;
`else
   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;
   typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
`endif

   rx_state_t         rx_state;
   logic              rx_s1, rx_s2, rx_s3;
   logic [CW-1:0]     rx_cnt;
   logic [BW-1:0]     rx_bits;
   logic              rx_stop;
   logic [DATA_W-1:0] rx_sh;

   tx_state_t         tx_state;
   logic [CW-1:0]     tx_cnt;
   logic [BW-1:0]     tx_bits;
   logic              tx_stop;
   logic [DATA_W-1:0] tx_sh;

`ifdef UART_PARITY_EN
   logic rx_par, rx_perr, tx_par;
   assign rx_perr = ^rx_sh ^ rx_par ^ ODD;
`else
   assign rx_parity_err = 1'b0;
`endif

   // RX: synchronise rxd, find the start edge, sample each bit at its centre
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         {rx_s3, rx_s2, rx_s1} <= 3'b111;
         rx_state     <= R_IDLE;
         rx_cnt       <= '0;
         rx_bits      <= '0;
         rx_stop      <= 1'b0;
         rx_sh        <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
         rx_par        <= 1'b0;
         rx_parity_err <= 1'b0;
`endif
      end else begin
         {rx_s3, rx_s2, rx_s1} <= {rx_s2, rx_s1, rxd};
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
         rx_parity_err <= 1'b0;
`endif
         rx_cnt <= rx_cnt + 1'b1;
         case (rx_state)
            R_IDLE: begin
               rx_cnt <= '0;
               if (rx_s3 && !rx_s2) rx_state <= R_START;
            end
            R_START: if (rx_cnt == HALF_LAST) begin
               rx_cnt   <= '0;
               rx_bits  <= '0;
               rx_state <= rx_s2 ? R_IDLE : R_DATA;
            end
            R_DATA: if (rx_cnt == LAST) begin
               rx_cnt  <= '0;
               rx_sh   <= {rx_s2, rx_sh[DATA_W-1:1]};
               rx_bits <= rx_bits + 1'b1;
               if (rx_bits == DLAST) begin
                  rx_stop  <= 1'b0;
`ifdef UART_PARITY_EN
                  rx_state <= R_PARITY;
`else
                  rx_state <= R_STOP;
`endif
               end
            end
`ifdef UART_PARITY_EN
            R_PARITY: if (rx_cnt == LAST) begin
               rx_cnt   <= '0;
               rx_par   <= rx_s2;
               rx_state <= R_STOP;
            end
`endif
            R_STOP: if (rx_cnt == LAST) begin
               rx_cnt <= '0;
               if (!rx_s2) begin
                  rx_frame_err <= 1'b1;
`ifdef UART_PARITY_EN
                  rx_parity_err <= rx_perr;
`endif
                  rx_state <= R_WAIT;
               end else if (rx_stop == SLAST) begin
                  rx_state <= R_IDLE;
`ifdef UART_PARITY_EN
                  if (rx_perr) rx_parity_err <= 1'b1;
                  else begin
                     rx_data  <= rx_sh;
                     rx_valid <= 1'b1;
                  end
`else
                  rx_data  <= rx_sh;
                  rx_valid <= 1'b1;
`endif
               end else rx_stop <= rx_stop + 1'b1;
            end
            R_WAIT: if (rx_s2) rx_state <= R_IDLE;
            default: rx_state <= R_IDLE;
         endcase
      end
   end

   // TX: accept a word on handshake and shift it out from a registered txd
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         tx_state <= T_IDLE;
         txd      <= 1'b1;
         tx_ready <= 1'b1;
         tx_cnt   <= '0;
         tx_bits  <= '0;
         tx_stop  <= 1'b0;
         tx_sh    <= '0;
`ifdef UART_PARITY_EN
         tx_par   <= 1'b0;
`endif
      end else begin
         tx_cnt <= tx_cnt + 1'b1;
         case (tx_state)
            T_IDLE: begin
               tx_cnt <= '0;
               if (tx_valid) begin
                  tx_sh    <= tx_data;
`ifdef UART_PARITY_EN
                  tx_par   <= ^tx_data ^ ODD;
`endif
                  txd      <= 1'b0;
                  tx_ready <= 1'b0;
                  tx_bits  <= '0;
                  tx_stop  <= 1'b0;
                  tx_state <= T_START;
               end
            end
            T_START: if (tx_cnt == LAST) begin
               tx_cnt   <= '0;
               txd      <= tx_sh[0];
               tx_state <= T_DATA;
            end
            T_DATA: if (tx_cnt == LAST) begin
               tx_cnt  <= '0;
               tx_sh   <= tx_sh >> 1;
               tx_bits <= tx_bits + 1'b1;
               if (tx_bits == DLAST) begin
`ifdef UART_PARITY_EN
                  txd      <= tx_par;
                  tx_state <= T_PARITY;
`else
                  txd      <= 1'b1;
                  tx_state <= T_STOP;
`endif
               end else txd <= tx_sh[1];
            end
`ifdef UART_PARITY_EN
            T_PARITY: if (tx_cnt == LAST) begin
               tx_cnt   <= '0;
               txd      <= 1'b1;
               tx_state <= T_STOP;
            end
`endif
            T_STOP: if (tx_cnt == LAST) begin
               tx_cnt <= '0;
               if (tx_stop == SLAST) begin
                  tx_state <= T_IDLE;
                  tx_ready <= 1'b1;
               end else tx_stop <= tx_stop + 1'b1;
            end
            default: tx_state <= T_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_param.sv
// tb_uart_param: scoreboard bench for uart_param (RX frames, glitch, framing error, TX, loopback, reset)
module tb_uart_param;
   localparam int W   = 8;
   localparam int CPB = 15;
   localparam int SB  = 1;
`ifdef UART_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int FRAME  = 1 + W + PB + SB;
   localparam int BIT_NS = CPB * 10;

   logic clk = 0, n_rst = 0, rxd_drv = 1, loop = 0, tx_valid = 0, tx_mon_en = 1;
   logic rxd, txd, tx_ready, rx_valid, rx_frame_err, rx_parity_err;
   logic [W-1:0] tx_data = '0, rx_data;
`ifdef UART_PARITY_EN
   logic par_flip = 0;
`endif

   always #5 clk = ~clk;
   assign rxd = loop ? txd : rxd_drv;

   uart_param #(.DATA_W(W), .CLKS_PER_BIT(CPB), .STOP_BITS(SB), .PARITY_ODD(0)) dut (
      .clk(clk), .n_rst(n_rst), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .txd(txd),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
   );

   int tests = 0, fails = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct packed {logic [2:0] fl; logic [W-1:0] d;} ev_t;
   ev_t rxq[$];
   logic [W-1:0] txq[$];

   task automatic exp_rx(input logic [2:0] fl, input logic [W-1:0] d);
      ev_t e;
      e.fl = fl;
      e.d  = d;
      rxq.push_back(e);
   endtask

   task automatic drive_rx(input logic [W-1:0] d, input int stop_low);
      @(negedge clk);
      rxd_drv = 0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < W; i++) begin
         rxd_drv = d[i];
         repeat (CPB) @(negedge clk);
      end
`ifdef UART_PARITY_EN
      rxd_drv = ^d ^ par_flip;
      repeat (CPB) @(negedge clk);
`endif
      if (stop_low > 0) begin
         rxd_drv = 0;
         repeat (stop_low) @(negedge clk);
      end
      rxd_drv = 1;
      repeat (SB * CPB + 2 * CPB) @(negedge clk);
   endtask

   task automatic tx_hs(input logic [W-1:0] d, output int n);
      tx_data  = d;
      tx_valid = 1;
      n = 0;
      while (!tx_ready && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (!tx_ready) check("tx_ready_timeout", 0, 1);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (n_rst && (rx_valid || rx_frame_err || rx_parity_err)) begin
         if (rxq.size() == 0) check("rx_unexpected", {29'd0, rx_valid, rx_frame_err, rx_parity_err}, 0);
         else begin
            ev_t e;
            e = rxq.pop_front();
            check("rx_flags", {29'd0, rx_valid, rx_frame_err, rx_parity_err}, {29'd0, e.fl});
            check("rx_data", rx_data, e.d);
         end
      end
   end

   initial begin : tx_mon
      logic [W-1:0] d, e;
      forever begin
         @(negedge txd);
         if (tx_mon_en && n_rst) begin
            e = (txq.size() != 0) ? txq.pop_front() : 'x;
            #(BIT_NS / 2);
            check("tx_start", txd, 0);
            for (int i = 0; i < W; i++) begin
               #(BIT_NS);
               d[i] = txd;
            end
            check("tx_data", d, e);
`ifdef UART_PARITY_EN
            #(BIT_NS);
            check("tx_parity", txd, ^e);
`endif
            for (int i = 0; i < SB; i++) begin
               #(BIT_NS);
               check("tx_stop", txd, 1);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, cnt;
      repeat (3) @(negedge clk);
      check("rst_txd", txd, 1);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_flags", {29'd0, rx_valid, rx_frame_err, rx_parity_err}, 0);
      n_rst = 1;
      repeat (5) @(negedge clk);

      exp_rx(3'b100, 8'hAB);
      drive_rx(8'hAB, 0);
      exp_rx(3'b010, 8'hAB);
      drive_rx(8'h55, 30);
      check("ferr_hold", rx_data, 8'hAB);
      exp_rx(3'b100, 8'h12);
      drive_rx(8'h12, 0);
      rxd_drv = 0;
      repeat (3) @(negedge clk);
      rxd_drv = 1;
      repeat (3 * CPB) @(negedge clk);
      check("glitch_hold", rx_data, 8'h12);
      exp_rx(3'b100, 8'h3C);
      drive_rx(8'h3C, 0);
`ifdef UART_PARITY_EN
      par_flip = 1;
      exp_rx(3'b001, 8'h3C);
      drive_rx(8'h96, 0);
      par_flip = 0;
      check("perr_hold", rx_data, 8'h3C);
`endif
      check("rxq_empty", rxq.size(), 0);

      txq.push_back(8'hAB);
      tx_hs(8'hAB, n);
      tx_valid = 0;
      check("tx_start_cycle", txd, 0);
      cnt = 0;
      while (!tx_ready && cnt < 4000) begin
         cnt++;
         @(negedge clk);
      end
      check("tx_ready_low", cnt, FRAME * CPB);
      repeat (CPB) @(negedge clk);

      loop = 1;
      txq.push_back(8'hAB);
      txq.push_back(8'hCD);
      exp_rx(3'b100, 8'hAB);
      exp_rx(3'b100, 8'hCD);
      tx_hs(8'hAB, n);
      tx_hs(8'hCD, n);
      tx_valid = 0;
      check("b2b_gap", n, FRAME * CPB);
      check("b2b_start", txd, 0);
      repeat (FRAME * CPB + 4 * CPB) @(negedge clk);
      loop = 0;
      check("loop_rxq_empty", rxq.size(), 0);
      check("loop_txq_empty", txq.size(), 0);

      tx_mon_en = 0;
      tx_hs(8'h5A, n);
      tx_valid = 0;
      repeat (40) @(negedge clk);
      check("tx_busy", tx_ready, 0);
      n_rst = 0;
      #1;
      check("midrst_txd", txd, 1);
      check("midrst_tx_ready", tx_ready, 1);
      check("midrst_rx_data", rx_data, 0);
      repeat (3) @(negedge clk);
      n_rst = 1;
      tx_mon_en = 1;
      repeat (3) @(negedge clk);

      txq.push_back(8'h3C);
      tx_hs(8'h3C, n);
      tx_valid = 0;
      repeat (FRAME * CPB + CPB) @(negedge clk);
      check("post_rst_txq_empty", txq.size(), 0);
      check("post_rst_tx_ready", tx_ready, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_param.md
Name: uart_param

Overview:
- Parametrised full-duplex UART: the next generation of the team's fixed 8-bit `uart`.
- RX detects its own start bit, so there is no `rx_start` strobe.
- Adds a TX ready/valid handshake, framing-error detection, configurable data width, configurable bit period and configurable stop-bit count.
- Sits between the serial pins and the calculator datapath. RX frames feed the command parser; results return through TX.

Parameters:
- DATA_W, 8, data bits per frame (5..16), sent and received LSB first.
- CLKS_PER_BIT, 15, clk cycles per serial bit (>=4).
- STOP_BITS, 1, stop bits per frame (1 or 2).
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only when UART_PARITY_EN is defined.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- n_rst  in  1  asynchronous active-low reset.
- rxd  in  1  serial input, idle high, asynchronous to clk.
- rx_data  out  DATA_W  last correctly received word; held until the next good frame.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- rx_frame_err  out  1  one-cycle pulse when a stop bit is sampled low.
- rx_parity_err  out  1  one-cycle pulse on parity mismatch; constant 0 without UART_PARITY_EN.
- txd  out  1  serial output, idle high.
- tx_data  in  DATA_W  word to send, sampled on handshake.
- tx_valid  in  1  word request.
- tx_ready  out  1  high when the transmitter can accept a word.

Behaviour:

Reset (asynchronous, immediate, also mid-frame; frames in flight are dropped):
- txd=1, tx_ready=1.
- rx_data=0, rx_valid=0, rx_frame_err=0, rx_parity_err=0.
- Both FSMs go to IDLE and all counters clear.

RX:
- rxd passes through a 2-flop synchroniser (reset value 1). All references below are to the synchronised signal.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
- IDLE -> START on a synchronised high-to-low transition.
- START: count CLKS_PER_BIT/2 cycles (integer division), then sample. Low -> DATA. High -> IDLE (glitch rejected, no output).
- DATA: sample every CLKS_PER_BIT cycles, DATA_W samples, shifting LSB first.
- STOP: sample STOP_BITS times, CLKS_PER_BIT apart.
- All stop samples high and no parity error: rx_data and rx_valid update on the cycle after the final stop sample; FSM -> IDLE.
- Any stop sample low: rx_frame_err pulses, rx_data is unchanged, FSM -> WAIT_IDLE.
  - Remaining stop samples are skipped.
  - If a parity error was also detected, rx_parity_err pulses in the same cycle.
- WAIT_IDLE (break handling): stay until rxd is sampled high, then -> IDLE.

TX:
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- tx_ready=1 only in IDLE.
- Handshake: a transfer happens when tx_valid && tx_ready at a rising edge. tx_data is latched; tx_valid is ignored while tx_ready=0.
- txd goes low on the cycle after the handshake.
- Each bit lasts exactly CLKS_PER_BIT cycles, data LSB first, then STOP_BITS high bits.
- tx_ready rises the cycle after the last stop-bit cycle.
- With tx_valid held high, frames run back to back: exactly one idle-high cycle (the handshake cycle) between frames.
- txd is driven from a register (glitch-free).

Concurrency:
- RX and TX are fully independent. Simultaneous activity on both has no interaction.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined:
  - One parity bit is inserted between the data bits and the stop bits on TX, and expected in the same place on RX.
  - Parity value is the XOR of the data bits; inverted when PARITY_ODD=1.
  - On RX mismatch: rx_parity_err pulses in the cycle after the final stop sample. rx_valid does not assert and rx_data holds. The FSM still checks the stop bits.
- Undefined:
  - No PARITY states exist.
  - rx_parity_err is tied 0.
  - Frame length is 1+DATA_W+STOP_BITS bits.

Test Plan (defaults, 10 ns clk):
- RX good frame: drive rxd 0,1,1,0,1,0,1,0,1,1 (start, 0xAB LSB first, stop), 150 ns per bit -> one rx_valid pulse with rx_data=0xAB, no error pulses.
- RX glitch: rxd low for 3 cycles, then high -> no rx_valid and no error; the next good frame with 0x3C is received correctly.
- RX framing error: 0x55 frame with the stop bit held low for 300 ns -> rx_frame_err pulses once, rx_data stays 0xAB, FSM waits for high; a following 0x12 frame is received.
- TX single: tx_data=0xAB, one-cycle tx_valid -> txd sequence 0,1,1,0,1,0,1,0,1,1, each bit 15 cycles. tx_ready low for 150 cycles, then high.
- TX back-to-back: tx_valid held with 0xAB then 0xCD -> second start bit begins 1 cycle after the first stop bit ends. Loopback txd->rxd yields rx_valid pulses with 0xAB then 0xCD.
- Parity and reset (macro defined, PARITY_ODD=0):
  - TX of 0xAB places parity bit 1 after the data bits.
  - RX frame with the parity bit flipped -> rx_parity_err pulse and no rx_valid.
  - n_rst asserted mid-TX -> txd=1 and tx_ready=1 immediately.
